prog_run_sequencer: RTL and testbench

PROG_RUN_SEQUENCER -- requirements
Module: prog_run_sequencer

---
 rtl/prog_seq_pkg.sv | 28 ++
 rtl/prog_run_sequencer_region_checker.sv | 60 ++++++
 rtl/prog_run_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_prog_run_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and default parameters for the program-run sequencer.
// The state enum is used by the top-level FSM.
package prog_seq_pkg;

    localparam int DEF_NUM_PROGS = 3;
    localparam int DEF_AW        = 8;
    localparam int DEF_DW        = 8;
    localparam int DEF_START_LEN = 1;
    localparam int DEF_CW        = 16;
    localparam int DEF_TIMEOUT   = 65535;
    localparam int DEF_MW        = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        CHECK,
        DRAIN,
        NEXT,
        FINISH
    } seq_state_t;

    // Index width that stays legal (>= 1 bit) even for a single program.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_run_sequencer_region_checker.sv
// Walks one memory region address by address and compares the processor
// and golden read data one cycle later, with no bubbles between reads.
module region_checker
    import prog_seq_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_start,
    input  logic [AW-1:0] i_lo,
    input  logic [AW-1:0] i_hi,
    input  logic [DW-1:0] i_dut_data,
    input  logic [DW-1:0] i_gold_data,
    output logic [AW-1:0] o_addr,
    output logic          o_empty,
    output logic          o_last,
    output logic          o_mis,
    output logic [AW-1:0] o_bad_addr
);

    logic          r_active;
    logic [AW-1:0] r_addr;
    logic          r_cmp_valid;
    logic [AW-1:0] r_cmp_addr;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_active    <= 1'b0;
            r_addr      <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
        end else begin
            r_cmp_valid <= r_active;
            r_cmp_addr  <= r_addr;
            if (i_start) begin
                r_active <= 1'b1;
                r_addr   <= i_lo;
            end else if (r_active) begin
                // Stop on the last address instead of incrementing, so hi = all-ones never wraps.
                if (r_addr == i_hi) begin
                    r_active <= 1'b0;
                    r_addr   <= '0;
                end else begin
                    r_addr <= r_addr + AW'(1);
                end
            end
        end
    end

    assign o_addr     = r_addr;
    assign o_empty    = (i_hi < i_lo);
    assign o_last     = r_active && (r_addr == i_hi);
    assign o_mis      = r_cmp_valid && (i_dut_data != i_gold_data);
    assign o_bad_addr = r_cmp_addr;

endmodule

// File: rtl/prog_run_sequencer.sv
// Runs NUM_PROGS programs on a processor in turn, waits for each Ack and
// checks a per-program memory region against a golden memory.
module prog_run_sequencer
    import prog_seq_pkg::*;
#(
    parameter int NUM_PROGS = DEF_NUM_PROGS,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int START_LEN = DEF_START_LEN,
    parameter int CW        = DEF_CW,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int MW        = DEF_MW
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               Run,
    input  logic [NUM_PROGS*AW-1:0]            CfgLo,
    input  logic [NUM_PROGS*AW-1:0]            CfgHi,
    output logic                               Start,
    input  logic                               Ack,
    output logic [AW-1:0]                      MemAddr,
    input  logic [DW-1:0]                      DutData,
    input  logic [DW-1:0]                      GoldData,
    output logic                               Busy,
    output logic                               Done,
    output logic                               Pass,
    output logic [NUM_PROGS-1:0]               ProgPass,
    output logic [idx_width(NUM_PROGS)-1:0]    ProgIdx,
    output logic [CW-1:0]                      CycleCnt,
    output logic [MW-1:0]                      MisCnt,
    output logic [AW-1:0]                      FirstBadAddr,
    output logic [DW-1:0]                      FirstBadExp,
    output logic [DW-1:0]                      FirstBadGot,
    output logic                               TimedOut
);

    localparam int PW = idx_width(NUM_PROGS);
    localparam int SW = idx_width(START_LEN);
    localparam logic [PW-1:0] LAST_IDX    = PW'(NUM_PROGS - 1);
    localparam logic [SW-1:0] START_LAST  = SW'(START_LEN - 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
    localparam logic [MW-1:0] MIS_MAX     = '1;

    seq_state_t            r_state;
    seq_state_t            w_state_nx;
    logic [SW-1:0]         r_start_cnt;
    logic                  r_ack_prev;
    logic [PW-1:0]         r_prog_idx;
    logic [NUM_PROGS-1:0]  r_prog_pass;
    logic [CW-1:0]         r_cycle_cnt;
    logic [MW-1:0]         r_mis_cnt;
    logic                  r_first_seen;
    logic [AW-1:0]         r_bad_addr;
    logic [DW-1:0]         r_bad_exp;
    logic [DW-1:0]         r_bad_got;
    logic                  r_timed_out;
    logic                  r_pass;

    logic [AW-1:0]         w_lo_arr [NUM_PROGS];
    logic [AW-1:0]         w_hi_arr [NUM_PROGS];
    logic [AW-1:0]         w_lo;
    logic [AW-1:0]         w_hi;
    logic [PW-1:0]         w_idx_inc;
    logic [CW-1:0]         w_cnt_inc;
    logic                  w_ack_rise;
    logic                  w_timeout;
    logic                  w_chk_start;
    logic                  w_empty;
    logic                  w_last;
    logic                  w_mis;
    logic [AW-1:0]         w_mis_addr;

    for (genvar g = 0; g < NUM_PROGS; g++) begin : g_cfg
        assign w_lo_arr[g] = CfgLo[g*AW +: AW];
        assign w_hi_arr[g] = CfgHi[g*AW +: AW];
    end

    assign w_lo       = w_lo_arr[r_prog_idx];
    assign w_hi       = w_hi_arr[r_prog_idx];
    assign w_idx_inc  = r_prog_idx + PW'(1);
    assign w_cnt_inc  = r_cycle_cnt + CW'(1);
    // Only a fresh 0->1 edge counts, so an Ack left high by the previous program is ignored.
    assign w_ack_rise = Ack && !r_ack_prev;
    assign w_timeout  = !w_ack_rise && (w_cnt_inc == TIMEOUT_CNT);

    region_checker #(
        .AW (AW),
        .DW (DW)
    ) u_checker (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_start     (w_chk_start),
        .i_lo        (w_lo),
        .i_hi        (w_hi),
        .i_dut_data  (DutData),
        .i_gold_data (GoldData),
        .o_addr      (MemAddr),
        .o_empty     (w_empty),
        .o_last      (w_last),
        .o_mis       (w_mis),
        .o_bad_addr  (w_mis_addr)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_nx  = r_state;
        w_chk_start = 1'b0;
        Start       = 1'b0;
        Busy        = 1'b1;
        Done        = 1'b0;
        case (r_state)
            IDLE: begin
                Busy = 1'b0;
                if (Run) w_state_nx = LAUNCH;
            end
            LAUNCH: begin
                Start = 1'b1;
                if (r_start_cnt == START_LAST) w_state_nx = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (w_ack_rise) begin
                    if (w_empty) begin
                        w_state_nx = NEXT;
                    end else begin
                        w_state_nx  = CHECK;
                        w_chk_start = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nx = NEXT;
                end
            end
            CHECK: begin
                if (w_last) w_state_nx = DRAIN;
            end
            DRAIN: begin
                w_state_nx = NEXT;
            end
            NEXT: begin
                w_state_nx = (r_prog_idx == LAST_IDX) ? FINISH : LAUNCH;
            end
            FINISH: begin
                Busy       = 1'b0;
                Done       = 1'b1;
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_start_cnt  <= '0;
            r_ack_prev   <= 1'b0;
            r_prog_idx   <= '0;
            r_prog_pass  <= '0;
            r_cycle_cnt  <= '0;
            r_mis_cnt    <= '0;
            r_first_seen <= 1'b0;
            r_bad_addr   <= '0;
            r_bad_exp    <= '0;
            r_bad_got    <= '0;
            r_timed_out  <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_ack_prev  <= Ack;
            r_start_cnt <= (r_state == LAUNCH) ? r_start_cnt + SW'(1) : '0;

            case (r_state)
                IDLE: begin
                    if (Run) begin
                        r_prog_idx   <= '0;
                        r_prog_pass  <= NUM_PROGS'(1);
                        r_cycle_cnt  <= '0;
                        r_mis_cnt    <= '0;
                        r_first_seen <= 1'b0;
                        r_bad_addr   <= '0;
                        r_bad_exp    <= '0;
                        r_bad_got    <= '0;
                        r_timed_out  <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end
                WAIT_ACK: begin
                    r_cycle_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_timed_out             <= 1'b1;
                        r_prog_pass[r_prog_idx] <= 1'b0;
                    end
                end
                NEXT: begin
                    // Pass is registered here so it is already valid during the Done cycle.
                    if (r_prog_idx == LAST_IDX) begin
                        r_pass <= (&r_prog_pass) && !r_timed_out;
                    end else begin
                        r_prog_idx             <= w_idx_inc;
                        r_cycle_cnt            <= '0;
                        r_prog_pass[w_idx_inc] <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_mis) begin
                r_prog_pass[r_prog_idx] <= 1'b0;
                if (r_mis_cnt != MIS_MAX) r_mis_cnt <= r_mis_cnt + MW'(1);
                if (!r_first_seen) begin
                    r_first_seen <= 1'b1;
                    r_bad_addr   <= w_mis_addr;
                    r_bad_exp    <= GoldData;
                    r_bad_got    <= DutData;
                end
            end
        end
    end

    assign Pass         = r_pass;
    assign ProgPass     = r_prog_pass;
    assign ProgIdx      = r_prog_idx;
    assign CycleCnt     = r_cycle_cnt;
    assign MisCnt       = r_mis_cnt;
    assign FirstBadAddr = r_bad_addr;
    assign FirstBadExp  = r_bad_exp;
    assign FirstBadGot  = r_bad_got;
    assign TimedOut     = r_timed_out;

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Scoreboard bench for prog_run_sequencer: a processor/memory model drives Ack
// and read data, expected results are queued at Run and compared at Done.
module tb_prog_run_sequencer;

    localparam int NP      = 3;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int SL      = 2;
    localparam int CW      = 16;
    localparam int TO      = 100;
    localparam int MW      = 8;
    localparam int PW      = 2;
    localparam int MAX_CYC = 5000;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Run;
    logic [NP*AW-1:0]  CfgLo;
    logic [NP*AW-1:0]  CfgHi;
    logic              Start;
    logic              Ack;
    logic [AW-1:0]     MemAddr;
    logic [DW-1:0]     DutData;
    logic [DW-1:0]     GoldData;
    logic              Busy;
    logic              Done;
    logic              Pass;
    logic [NP-1:0]     ProgPass;
    logic [PW-1:0]     ProgIdx;
    logic [CW-1:0]     CycleCnt;
    logic [MW-1:0]     MisCnt;
    logic [AW-1:0]     FirstBadAddr;
    logic [DW-1:0]     FirstBadExp;
    logic [DW-1:0]     FirstBadGot;
    logic              TimedOut;

    always #5 Clk = ~Clk;

    prog_run_sequencer #(
        .NUM_PROGS (NP),
        .AW        (AW),
        .DW        (DW),
        .START_LEN (SL),
        .CW        (CW),
        .TIMEOUT   (TO),
        .MW        (MW)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .CfgLo        (CfgLo),
        .CfgHi        (CfgHi),
        .Start        (Start),
        .Ack          (Ack),
        .MemAddr      (MemAddr),
        .DutData      (DutData),
        .GoldData     (GoldData),
        .Busy         (Busy),
        .Done         (Done),
        .Pass         (Pass),
        .ProgPass     (ProgPass),
        .ProgIdx      (ProgIdx),
        .CycleCnt     (CycleCnt),
        .MisCnt       (MisCnt),
        .FirstBadAddr (FirstBadAddr),
        .FirstBadExp  (FirstBadExp),
        .FirstBadGot  (FirstBadGot),
        .TimedOut     (TimedOut)
    );

    logic [DW-1:0] dut_mem  [256];
    logic [DW-1:0] gold_mem [256];

    // Both memories return data one cycle after the address.
    always @(posedge Clk) begin
        DutData  <= dut_mem[MemAddr];
        GoldData <= gold_mem[MemAddr];
    end

    typedef struct {
        logic          pass;
        logic [NP-1:0] pp;
        logic [MW-1:0] mis;
        logic [AW-1:0] fa;
        logic [DW-1:0] fe;
        logic [DW-1:0] fg;
        logic          to;
        logic [CW-1:0] cyc;
        int            addrs;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_q[$];

    int   lo[NP];
    int   hi[NP];
    int   ack_d[NP];
    int   drop_at[NP];
    bit   hold[NP];
    int   rst_prog;
    bit   run_mid;
    int   n_checks = 0;
    int   n_fails  = 0;

    function automatic logic [127:0] all_outs();
        return 128'({Start, Busy, Done, Pass, ProgPass, ProgIdx, CycleCnt, MisCnt,
                     FirstBadAddr, FirstBadExp, FirstBadGot, TimedOut, MemAddr});
    endfunction

    task automatic init_mems();
        for (int a = 0; a < 256; a++) begin
            gold_mem[a] = 8'(a * 7 + 3);
            dut_mem[a]  = gold_mem[a];
        end
    endtask

    task automatic set_defaults();
        lo[0] = 30;  hi[0] = 59;
        lo[1] = 94;  hi[1] = 123;
        lo[2] = 192; hi[2] = 194;
        for (int i = 0; i < NP; i++) begin
            ack_d[i]   = 50;
            drop_at[i] = 0;
            hold[i]    = 1'b0;
        end
        rst_prog = -1;
        run_mid  = 1'b0;
    endtask

    task automatic build_expected();
        exp_t e;
        int   mis;
        bit   seen;
        mis     = 0;
        seen    = 1'b0;
        e.pp    = '0;
        e.fa    = '0;
        e.fe    = '0;
        e.fg    = '0;
        e.to    = 1'b0;
        e.addrs = 0;
        for (int p = 0; p < NP; p++) begin
            e.pp[p] = 1'b1;
            if (ack_d[p] == 0) begin
                e.to    = 1'b1;
                e.pp[p] = 1'b0;
            end else begin
                cyc_q.push_back(ack_d[p]);
                for (int a = lo[p]; a <= hi[p]; a++) begin
                    if (a != 0) e.addrs++;
                    if (dut_mem[a] != gold_mem[a]) begin
                        mis++;
                        e.pp[p] = 1'b0;
                        if (!seen) begin
                            seen = 1'b1;
                            e.fa = AW'(a);
                            e.fe = gold_mem[a];
                            e.fg = dut_mem[a];
                        end
                    end
                end
            end
        end
        e.mis  = (mis > 255) ? MW'(255) : MW'(mis);
        e.pass = (&e.pp) && !e.to;
        e.cyc  = (ack_d[NP-1] > 0) ? CW'(ack_d[NP-1]) : CW'(TO);
        exp_q.push_back(e);
    endtask

    task automatic run_seq(input string name);
        exp_t e;
        int   p, k, slen, addr_cnt, exp_cyc, exp_addrs;
        bit   prev_start, done_seen, aborted, idle_bad;
        for (int i = 0; i < NP; i++) begin
            CfgLo[i*AW +: AW] = AW'(lo[i]);
            CfgHi[i*AW +: AW] = AW'(hi[i]);
        end
        build_expected();
        Ack = 1'b0;
        @(negedge Clk); Run = 1'b1;
        @(negedge Clk); Run = 1'b0;
        p = -1; k = 0; slen = 0; addr_cnt = 0; exp_addrs = 0;
        prev_start = 1'b0; done_seen = 1'b0; aborted = 1'b0;
        for (int cyc = 0; cyc < MAX_CYC && !done_seen && !aborted; cyc++) begin
            Run = 1'b0;
            if (MemAddr != '0) addr_cnt++;
            if (Start) begin
                if (!prev_start) begin
                    p++;
                    slen = 0;
                    if (p == 0 || (p <= NP && !hold[p-1])) Ack = 1'b0;
                end
                slen++;
                k = 0;
            end else begin
                if (prev_start) begin
                    n_checks++;
                    if (slen != SL) begin
                        n_fails++;
                        $display("FAIL %s start_len prog %0d: got %0d cycles, expected %0d", name, p, slen, SL);
                    end
                    k = 1;
                end else if (k > 0) begin
                    k++;
                end
                if (k > 0 && p >= 0 && p < NP) begin
                    if (drop_at[p] > 0 && k == drop_at[p]) Ack = 1'b0;
                    if (ack_d[p] > 0 && k == ack_d[p]) Ack = 1'b1;
                    if (ack_d[p] > 0 && k == ack_d[p] + 1) begin
                        exp_cyc = (cyc_q.size() > 0) ? cyc_q.pop_front() : -1;
                        n_checks++;
                        if (int'(CycleCnt) != exp_cyc) begin
                            n_fails++;
                            $display("FAIL %s cycle_cnt prog %0d: got %0d, expected %0d", name, p, CycleCnt, exp_cyc);
                        end
                    end
                    if (run_mid && p == 1 && k == 5) Run = 1'b1;
                    if (p == rst_prog && k == ack_d[p] + 3) begin
                        Reset = 1'b1;
                        @(negedge Clk);
                        Reset = 1'b0;
                        n_checks++;
                        if (all_outs() !== '0) begin
                            n_fails++;
                            $display("FAIL %s reset_mid_check: outputs 0x%0h, expected 0", name, all_outs());
                        end
                        aborted = 1'b1;
                    end
                end
            end
            if (Done && !aborted) begin
                done_seen = 1'b1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_addrs = e.addrs;
                    n_checks++;
                    if (Pass !== e.pass) begin
                        n_fails++; $display("FAIL %s pass: got %b, expected %b", name, Pass, e.pass);
                    end
                    n_checks++;
                    if (ProgPass !== e.pp) begin
                        n_fails++; $display("FAIL %s prog_pass: got %b, expected %b", name, ProgPass, e.pp);
                    end
                    n_checks++;
                    if (MisCnt !== e.mis) begin
                        n_fails++; $display("FAIL %s mis_cnt: got %0d, expected %0d", name, MisCnt, e.mis);
                    end
                    n_checks++;
                    if ({FirstBadAddr, FirstBadExp, FirstBadGot} !== {e.fa, e.fe, e.fg}) begin
                        n_fails++;
                        $display("FAIL %s first_bad: got addr %0d exp 0x%h got 0x%h, expected addr %0d exp 0x%h got 0x%h",
                                 name, FirstBadAddr, FirstBadExp, FirstBadGot, e.fa, e.fe, e.fg);
                    end
                    n_checks++;
                    if (TimedOut !== e.to) begin
                        n_fails++; $display("FAIL %s timed_out: got %b, expected %b", name, TimedOut, e.to);
                    end
                    n_checks++;
                    if (CycleCnt !== e.cyc) begin
                        n_fails++; $display("FAIL %s last_cycle_cnt: got %0d, expected %0d", name, CycleCnt, e.cyc);
                    end
                    n_checks++;
                    if ({Busy, ProgIdx} !== {1'b0, PW'(NP - 1)}) begin
                        n_fails++; $display("FAIL %s done_state: got busy %b idx %0d, expected busy 0 idx %0d", name, Busy, ProgIdx, NP - 1);
                    end
                end else begin
                    n_checks++; n_fails++;
                    $display("FAIL %s done: unexpected Done pulse, got 1, expected 0", name);
                end
            end
            prev_start = Start;
            if (!done_seen && !aborted) @(negedge Clk);
        end
        if (aborted) begin
            exp_q.delete();
            cyc_q.delete();
            idle_bad = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge Clk);
                if (Done || Busy) idle_bad = 1'b1;
            end
            n_checks++;
            if (idle_bad) begin
                n_fails++; $display("FAIL %s abort_idle: got Done/Busy activity 1, expected 0", name);
            end
        end else if (!done_seen) begin
            n_checks++; n_fails++;
            $display("FAIL %s done_timeout: got no Done in %0d cycles, expected Done", name, MAX_CYC);
        end else begin
            n_checks++;
            if (addr_cnt != exp_addrs) begin
                n_fails++; $display("FAIL %s addr_count: got %0d nonzero addresses, expected %0d", name, addr_cnt, exp_addrs);
            end
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b0; Ack = 1'b0; CfgLo = '0; CfgHi = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fails++; $display("FAIL reset_state: outputs 0x%0h, expected 0", all_outs());
        end
        Reset = 1'b1; Run = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; Run = 1'b0;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fails++; $display("FAIL reset_over_run: outputs 0x%0h, expected 0", all_outs());
        end
        @(negedge Clk);
    endtask

    task automatic test_all_pass();
        set_defaults();
        run_mid = 1'b1;
        run_seq("all_pass");
    endtask

    task automatic test_mismatch();
        set_defaults();
        gold_mem[100] = 8'h5A;
        dut_mem[100]  = 8'h00;
        run_seq("mismatch");
        init_mems();
    endtask

    task automatic test_stale_ack();
        set_defaults();
        hold[0]    = 1'b1;
        drop_at[1] = 10;
        run_seq("stale_ack");
    endtask

    task automatic test_timeout();
        set_defaults();
        ack_d[2] = 0;
        run_seq("timeout");
    endtask

    task automatic test_boundary();
        set_defaults();
        lo[0] = 250; hi[0] = 255;
        lo[1] = 20;  hi[1] = 10;
        lo[2] = 3;   hi[2] = 4;
        dut_mem[255] = ~gold_mem[255];
        run_seq("boundary");
        init_mems();
    endtask

    task automatic test_saturation();
        set_defaults();
        for (int i = 0; i < NP; i++) begin
            lo[i] = 0;
            hi[i] = 255;
            ack_d[i] = 20;
        end
        for (int a = 0; a < 256; a++) dut_mem[a] = ~gold_mem[a];
        run_seq("saturation");
        init_mems();
    endtask

    task automatic test_reset_mid_check();
        set_defaults();
        rst_prog = 1;
        run_seq("reset_mid");
        set_defaults();
        run_seq("after_reset");
    endtask

    initial begin
        init_mems();
        Reset = 1'b0; Run = 1'b0; Ack = 1'b0;
        test_reset();
        test_all_pass();
        test_mismatch();
        test_stale_ack();
        test_timeout();
        test_boundary();
        test_saturation();
        test_reset_mid_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
